id_stage_s: RTL and testbench

ID_STAGE_S -- requirements
Module: id_stage_s

---
 rtl/cpu_pkg_s.sv | 58 +++++
 rtl/id_stage_s_if.sv | 19 +
 rtl/regfile_s.sv | 51 +++++
 rtl/id_stage_s.sv | 201 ++++++++++++++++++++
 tb/tb_id_stage_s.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg_s.sv
// Shared decode definitions for the ID stage: RV32I opcode constants,
// immediate-format enum, the ID/EX bundle struct and an immediate generator.
package cpu_pkg_s;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // ID/EX pipeline bundle; an all-zero value is a bubble.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [6:0]  opcode;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
    } id_ex_t;

    // Sign-extended immediate for the given instruction format.
    function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_e fmt);
        logic [31:0] imm;
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/id_stage_s_if.sv
// Fetch <-> decode handshake: fetched instruction in, stall/redirect back out.
interface id_stage_s_if;
    logic        if_is_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        is_stall;
    logic        is_flush;
    logic [31:0] branch_target;

    modport master (
        output if_is_valid, if_pc, if_instr,
        input  is_stall, is_flush, branch_target
    );

    modport slave (
        input  if_is_valid, if_pc, if_instr,
        output is_stall, is_flush, branch_target
    );
endinterface

// File: rtl/regfile_s.sv
// 32x32 register file: two asynchronous read ports with write-first bypass,
// one write port, x0 hard-wired to zero, asynchronous active-low clear.
module regfile_s (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0] regs_q [32];

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_reg
            // One register per entry; entry 0 is never written.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs_q[gi] <= '0;
                end else if (we_i && (gi != 0) && (waddr_i == 5'(gi))) begin
                    regs_q[gi] <= wdata_i;
                end
            end
        end
    endgenerate

    // Read port 1: x0 is zero, a same-cycle write to the same register wins.
    always_comb begin
        rdata1_o = regs_q[raddr1_i];
        if (raddr1_i == 5'd0) begin
            rdata1_o = '0;
        end else if (we_i && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        rdata2_o = regs_q[raddr2_i];
        if (raddr2_i == 5'd0) begin
            rdata2_o = '0;
        end else if (we_i && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
    end

endmodule

// File: rtl/id_stage_s.sv
// RV32I decode stage: decodes the fetched word, reads the register file,
// detects load-use hazards and registers the ID/EX bundle.
// Optional macro BRANCH_IN_ID_EN resolves JAL/BEQ/BNE here and redirects fetch.
module id_stage_s
    import cpu_pkg_s::*;
(
    input  logic         clk,
    input  logic         reset,
    id_stage_s_if.slave  fe,
    input  logic         wb_we,
    input  logic [4:0]   wb_rd,
    input  logic [31:0]  wb_data,
    output logic         id_is_valid,
    output logic [31:0]  id_pc,
    output logic [31:0]  id_rs1_data,
    output logic [31:0]  id_rs2_data,
    output logic [31:0]  id_imm,
    output logic [4:0]   id_rd,
    output logic [2:0]   id_funct3,
    output logic         id_funct7b5,
    output logic [6:0]   id_opcode,
    output logic         id_mem_read,
    output logic         id_mem_write,
    output logic         id_reg_write
);

    id_ex_t      id_ex_q;
    id_ex_t      id_ex_d;
    logic        flush_q;
    logic        live;
    logic        is_stall;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    logic        known;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_reg_write;
    imm_fmt_e    fmt;

    assign opcode = fe.if_instr[6:0];
    assign rd     = fe.if_instr[11:7];
    assign funct3 = fe.if_instr[14:12];
    assign rs1    = fe.if_instr[19:15];
    assign rs2    = fe.if_instr[24:20];

    // Opcode decode: unknown opcodes leave every control at 0 (bubble).
    always_comb begin
        known         = 1'b0;
        uses_rs1      = 1'b0;
        uses_rs2      = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_reg_write = 1'b0;
        fmt           = IMM_NONE;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                known = 1'b1; dec_reg_write = 1'b1; fmt = IMM_U;
            end
            OP_JAL: begin
                known = 1'b1; dec_reg_write = 1'b1; fmt = IMM_J;
            end
            OP_JALR, OP_IMM: begin
                known = 1'b1; uses_rs1 = 1'b1; dec_reg_write = 1'b1; fmt = IMM_I;
            end
            OP_LOAD: begin
                known = 1'b1; uses_rs1 = 1'b1; dec_mem_read = 1'b1;
                dec_reg_write = 1'b1; fmt = IMM_I;
            end
            OP_STORE: begin
                known = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                dec_mem_write = 1'b1; fmt = IMM_S;
            end
            OP_BRANCH: begin
                known = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; fmt = IMM_B;
            end
            OP_REG: begin
                known = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; dec_reg_write = 1'b1;
            end
            default: begin
                known = 1'b0;
            end
        endcase
    end

    assign imm = imm_gen(fe.if_instr, fmt);

    regfile_s u_regfile (
        .clk      (clk),
        .rst_n    (reset),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rs1_data),
        .rdata2_o (rs2_data),
        .we_i     (wb_we),
        .waddr_i  (wb_rd),
        .wdata_i  (wb_data)
    );

    // Instructions arriving one cycle after a redirect are wrong-path.
    assign live = fe.if_is_valid & ~flush_q;

    // Load-use hazard against the load currently sitting in ID/EX.
    always_comb begin
        is_stall = 1'b0;
        if (live && id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd != 5'd0)) begin
            if ((uses_rs1 && (rs1 == id_ex_q.rd)) || (uses_rs2 && (rs2 == id_ex_q.rd))) begin
                is_stall = 1'b1;
            end
        end
    end

    assign fe.is_stall = is_stall;

`ifdef BRANCH_IN_ID_EN
    logic br_taken;
    logic flush_d;

    // Early branch resolution on bypassed operands; stall suppresses it.
    always_comb begin
        br_taken = 1'b0;
        if (opcode == OP_JAL) begin
            br_taken = 1'b1;
        end else if (opcode == OP_BRANCH) begin
            if (funct3 == F3_BEQ) begin
                br_taken = (rs1_data == rs2_data);
            end else if (funct3 == F3_BNE) begin
                br_taken = (rs1_data != rs2_data);
            end
        end
    end

    assign flush_d          = live & ~is_stall & br_taken;
    assign fe.is_flush      = flush_d;
    assign fe.branch_target = fe.if_pc + imm;

    // Remember a redirect for exactly one cycle to squash the wrong-path fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_q <= 1'b0;
        end else begin
            flush_q <= flush_d;
        end
    end
`else
    assign fe.is_flush      = 1'b0;
    assign fe.branch_target = '0;
    assign flush_q          = 1'b0;
`endif

    // Next ID/EX contents: the decoded instruction, or an all-zero bubble.
    always_comb begin
        id_ex_d = '0;
        if (live && !is_stall && known) begin
            id_ex_d.valid     = 1'b1;
            id_ex_d.pc        = fe.if_pc;
            id_ex_d.rs1_data  = rs1_data;
            id_ex_d.rs2_data  = rs2_data;
            id_ex_d.imm       = imm;
            id_ex_d.rd        = rd;
            id_ex_d.funct3    = funct3;
            id_ex_d.funct7b5  = fe.if_instr[30];
            id_ex_d.opcode    = opcode;
            id_ex_d.mem_read  = dec_mem_read;
            id_ex_d.mem_write = dec_mem_write;
            id_ex_d.reg_write = dec_reg_write;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign id_is_valid  = id_ex_q.valid;
    assign id_pc        = id_ex_q.pc;
    assign id_rs1_data  = id_ex_q.rs1_data;
    assign id_rs2_data  = id_ex_q.rs2_data;
    assign id_imm       = id_ex_q.imm;
    assign id_rd        = id_ex_q.rd;
    assign id_funct3    = id_ex_q.funct3;
    assign id_funct7b5  = id_ex_q.funct7b5;
    assign id_opcode    = id_ex_q.opcode;
    assign id_mem_read  = id_ex_q.mem_read;
    assign id_mem_write = id_ex_q.mem_write;
    assign id_reg_write = id_ex_q.reg_write;

endmodule

// File: tb/tb_id_stage_s.sv
// Randomized and directed bench for id_stage_s against a behavioural model.
// Honors BRANCH_IN_ID_EN the same way as the design.
module tb_id_stage_s;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        id_is_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rd;
    logic [2:0]  id_funct3;
    logic        id_funct7b5;
    logic [6:0]  id_opcode;
    logic        id_mem_read, id_mem_write, id_reg_write;

    id_stage_s_if fe_if ();

    id_stage_s dut (
        .clk          (clk),
        .reset        (reset),
        .fe           (fe_if),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .id_is_valid  (id_is_valid),
        .id_pc        (id_pc),
        .id_rs1_data  (id_rs1_data),
        .id_rs2_data  (id_rs2_data),
        .id_imm       (id_imm),
        .id_rd        (id_rd),
        .id_funct3    (id_funct3),
        .id_funct7b5  (id_funct7b5),
        .id_opcode    (id_opcode),
        .id_mem_read  (id_mem_read),
        .id_mem_write (id_mem_write),
        .id_reg_write (id_reg_write)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [32];
    logic        m_flush;
    logic        m_valid, m_mr, m_mw, m_rw, m_f7;
    logic [31:0] m_pc, m_r1, m_r2, m_imm;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [6:0]  m_op;
    logic        obs_stall, obs_flush;
    logic [31:0] obs_target;

    task automatic model_clear_bundle();
        m_valid = 0; m_mr = 0; m_mw = 0; m_rw = 0; m_f7 = 0;
        m_pc = 0; m_r1 = 0; m_r2 = 0; m_imm = 0; m_rd = 0; m_f3 = 0; m_op = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_flush = 1'b0;
        model_clear_bundle();
    endtask

    // {known, uses_rs1, uses_rs2, mem_read, mem_write, reg_write} per RV32I opcode
    function automatic logic [5:0] op_class(input logic [6:0] op);
        case (op)
            7'b0110111, 7'b0010111, 7'b1101111: return 6'b100001;
            7'b1100111, 7'b0010011:             return 6'b110001;
            7'b1100011:                         return 6'b111000;
            7'b0000011:                         return 6'b110101;
            7'b0100011:                         return 6'b111010;
            7'b0110011:                         return 6'b111001;
            default:                            return 6'b000000;
        endcase
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        case (i[6:0])
            7'b1100111, 7'b0010011, 7'b0000011: return {{20{i[31]}}, i[31:20]};
            7'b0100011: return {{20{i[31]}}, i[31:25], i[11:7]};
            7'b1100011: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            7'b0110111, 7'b0010111: return {i[31:12], 12'b0};
            7'b1101111: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
        if (we && wa == a) return wd;
        return m_regs[a];
    endfunction

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] off, input logic [4:0] rd);
        return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
    endfunction

    task automatic check_bundle();
        check("id_valid", id_is_valid, m_valid);
        check("id_pc", id_pc, m_pc);
        check("id_rs1_data", id_rs1_data, m_r1);
        check("id_rs2_data", id_rs2_data, m_r2);
        check("id_imm", id_imm, m_imm);
        check("id_rd", id_rd, m_rd);
        check("id_funct3", id_funct3, m_f3);
        check("id_funct7b5", id_funct7b5, m_f7);
        check("id_opcode", id_opcode, m_op);
        check("id_mem_read", id_mem_read, m_mr);
        check("id_mem_write", id_mem_write, m_mw);
        check("id_reg_write", id_reg_write, m_rw);
    endtask

    // One transaction: called at a falling edge, returns at the next one.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic we, input logic [4:0] wrd, input logic [31:0] wd);
        logic [5:0]  cls;
        logic [31:0] imm, r1, r2;
        logic [4:0]  s1, s2;
        logic        live, stall, flush;
        check_bundle();
        fe_if.if_is_valid = v;
        fe_if.if_pc       = pc;
        fe_if.if_instr    = ins;
        wb_we = we; wb_rd = wrd; wb_data = wd;
        #1;
        cls  = op_class(ins[6:0]);
        imm  = ref_imm(ins);
        s1   = ins[19:15];
        s2   = ins[24:20];
        r1   = ref_read(s1, we, wrd, wd);
        r2   = ref_read(s2, we, wrd, wd);
        live = v && !m_flush;
        stall = live && m_valid && m_mr && (m_rd != 0) &&
                ((cls[4] && s1 == m_rd) || (cls[3] && s2 == m_rd));
`ifdef BRANCH_IN_ID_EN
        flush = live && !stall &&
                (ins[6:0] == 7'b1101111 ||
                 (ins[6:0] == 7'b1100011 &&
                  ((ins[14:12] == 3'd0 && r1 == r2) || (ins[14:12] == 3'd1 && r1 != r2))));
`else
        flush = 1'b0;
`endif
        obs_stall  = fe_if.is_stall;
        obs_flush  = fe_if.is_flush;
        obs_target = fe_if.branch_target;
        check("is_stall", obs_stall, stall);
        check("is_flush", obs_flush, flush);
`ifdef BRANCH_IN_ID_EN
        if (flush) check("branch_target", obs_target, pc + imm);
`else
        check("branch_target", obs_target, 32'h0);
`endif
        $display("[%0t] v=%0b pc=%h ins=%h wb=%0b/%0d/%h stall=%0b flush=%0b",
                 $time, v, pc, ins, we, wrd, wd, obs_stall, obs_flush);
        model_clear_bundle();
        if (live && !stall && cls[5]) begin
            m_valid = 1; m_pc = pc; m_r1 = r1; m_r2 = r2; m_imm = imm;
            m_rd = ins[11:7]; m_f3 = ins[14:12]; m_f7 = ins[30]; m_op = ins[6:0];
            m_mr = cls[2]; m_mw = cls[1]; m_rw = cls[0];
        end
        m_flush = flush;
        if (we && wrd != 0) m_regs[wrd] = wd;
        @(negedge clk);
    endtask

    logic [31:0] r_ins, r_pc;
    logic [6:0]  r_op;
    logic [6:0]  ops [11];

    initial begin
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                7'b0100011, 7'b0010011, 7'b0110011, 7'b0000011, 7'b1111111};
        reset = 1'b0;
        fe_if.if_is_valid = 0; fe_if.if_pc = 0; fe_if.if_instr = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0;
        model_reset();
        #2;
        check_bundle();
        check("reset_stall", fe_if.is_stall, 1'b0);
        check("reset_flush", fe_if.is_flush, 1'b0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        // ADDI x1,x0,5 is issued with latency one
        cycle(1, 32'h0, enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011), 0, 0, 0);
        check("req028_valid", id_is_valid, 1'b1);
        check("req028_imm", id_imm, 32'd5);
        check("req028_rd", id_rd, 5'd1);
        check("req028_regwrite", id_reg_write, 1'b1);

        // same-cycle write-back bypass
        cycle(1, 32'h4, enc_r(5'd0, 5'd3, 5'd4), 1, 5'd3, 32'hDEADBEEF);
        check("req029_rs1", id_rs1_data, 32'hDEADBEEF);

        // load-use stall then reissue
        cycle(1, 32'h8, enc_i(12'd0, 5'd2, 3'b010, 5'd5, 7'b0000011), 0, 0, 0);
        cycle(1, 32'hC, enc_r(5'd1, 5'd5, 5'd6), 0, 0, 0);
        check("req030_stall", obs_stall, 1'b1);
        check("req030_bubble", id_is_valid, 1'b0);
        cycle(1, 32'hC, enc_r(5'd1, 5'd5, 5'd6), 0, 0, 0);
        check("req030_nostall", obs_stall, 1'b0);
        check("req030_issue", id_is_valid, 1'b1);
        check("req030_rd", id_rd, 5'd6);

        // BEQ with load-use on rs1: stall wins over any redirect
        cycle(1, 32'h10, enc_i(12'd0, 5'd2, 3'b010, 5'd5, 7'b0000011), 0, 0, 0);
        cycle(1, 32'h40, enc_b(13'd8, 5'd0, 5'd5, 3'b000), 0, 0, 0);
        check("req032_stall", obs_stall, 1'b1);
        check("req032_flush", obs_flush, 1'b0);
        cycle(1, 32'h40, enc_b(13'd8, 5'd0, 5'd5, 3'b000), 0, 0, 0);
        check("req032_resolved", obs_stall, 1'b0);
        check("req032_issue", id_opcode, 7'b1100011);
        cycle(0, 32'h0, 32'h0, 0, 0, 0);

`ifdef BRANCH_IN_ID_EN
        // JAL redirect and squash of the next fetch
        cycle(1, 32'h20, enc_j(21'd16, 5'd1), 0, 0, 0);
        check("req031_flush", obs_flush, 1'b1);
        check("req031_target", obs_target, 32'h30);
        check("req031_jal_issued", id_opcode, 7'b1101111);
        cycle(1, 32'h24, enc_i(12'd1, 5'd0, 3'b000, 5'd7, 7'b0010011), 0, 0, 0);
        check("req031_squash_flush", obs_flush, 1'b0);
        check("req031_squashed", id_is_valid, 1'b0);
        // PC wrap
        cycle(1, 32'hFFFFFFFC, enc_j(21'd8, 5'd0), 0, 0, 0);
        check("wrap_target", obs_target, 32'h4);
        cycle(0, 32'h0, 32'h0, 0, 0, 0);
`else
        cycle(1, 32'hFFFFFFFC, enc_j(21'd8, 5'd0), 0, 0, 0);
        check("wrap_pc", id_pc, 32'hFFFFFFFC);
`endif

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            r_ins = $urandom;
            r_op  = ops[$urandom_range(0, 10)];
            if (r_op == 7'b1111111) r_op = 7'($urandom);
            r_ins[6:0]   = r_op;
            r_ins[11:7]  = 5'($urandom_range(0, 7));
            r_ins[19:15] = 5'($urandom_range(0, 7));
            r_ins[24:20] = 5'($urandom_range(0, 7));
            if (r_op == 7'b1100011 && $urandom_range(0, 3) != 0)
                r_ins[14:12] = 3'($urandom_range(0, 1));
            r_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFF_FFFC);
            cycle($urandom_range(0, 9) != 0, r_pc, r_ins, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom));
        end

        // asynchronous reset in the middle of a stall
        cycle(1, 32'h80, enc_i(12'd0, 5'd2, 3'b010, 5'd5, 7'b0000011), 0, 0, 0);
        fe_if.if_is_valid = 1; fe_if.if_pc = 32'h84; fe_if.if_instr = enc_r(5'd1, 5'd5, 5'd6);
        wb_we = 0;
        #1;
        check("req033_stall_before", fe_if.is_stall, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        check_bundle();
        check("req033_stall_after", fe_if.is_stall, 1'b0);
        check("req033_flush_after", fe_if.is_flush, 1'b0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        cycle(1, 32'h84, enc_r(5'd1, 5'd5, 5'd6), 0, 0, 0);
        check("req033_cold_issue", id_is_valid, 1'b1);
        cycle(0, 32'h0, 32'h0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
